ram8: RTL and testbench
=======================

Name: ram8

Overview:
- Eight-word register file (Hack-style RAM8) and the direct consumer of the 8-way load demultiplexer.
- The `load` input is routed to exactly one of eight word registers, selected by `address`.
- Read data is the word at `address`, selected combinationally.
- Forms the base building block for the larger RAM stages (RAM64 and up) in the CPU memory hierarchy.

Parameters:
- WIDTH, 16, data word width in bits (the Hack word). Legal values 1..64.

Ports:
- clk, input, 1, system clock. All writes occur on the rising edge.
- rst_n, input, 1, asynchronous active-low reset. Clears all eight words.
- in, input, WIDTH, write data.
- load, input, 1, write enable for the word selected by address.
- address, input, 3, word select for both read and write.
- out, output, WIDTH, contents of the word currently selected by address.

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Storage: eight registers, mem[0..7], each WIDTH bits.
- Reset:
  - rst_n low sets mem[0..7] = 0 immediately, independent of clk.
  - out = 0 while rst_n is low, for any address.
  - Writes are ignored while rst_n is low.
- Write:
  - At each clk rising edge with rst_n high and load=1, mem[address] <= in.
  - All other words hold their value.
  - load=0 leaves all words unchanged.
- Load routing: per-word enable en[k] = load AND (address == k). Exactly one word is enabled when load=1; none are enabled when load=0.
- Read:
  - out = mem[address], purely combinational. Zero-cycle latency from an address change.
  - One-cycle latency from a write: the new data appears on out after the edge that writes it.
- Read-during-write, same address: before the edge, out shows the old value; after the edge, out shows the new value. No bypass of `in` to `out`.
- Reset release:
  - The first write takes effect at the first clk rising edge after rst_n goes high.
  - rst_n must not be released within the setup/hold window of a clk edge. The bench respects this.
- Reset mid-operation: rst_n asserted between edges clears all words at once, including a word written on the preceding edge.
- Address wrap: all 3-bit address values are valid. No out-of-range condition exists.
- Width rule: in, out and mem are all exactly WIDTH bits. No truncation or extension.
- X handling: load=1 with address containing X/Z is illegal stimulus. The bench does not drive it.

Decomposition:
- Shared package:
  - HACK_WORD_W = 16 (default for WIDTH).
  - RAM8_ADDR_W = 3.
  - RAM8_DEPTH = 8.
- Sub-module `word_reg`:
  - Parameterised by WIDTH; ports clk, rst_n, in, load, out.
  - Async active-low clear; loads in on the clk rising edge when load=1.
  - ram8 instantiates it eight times.
- Load routing reuses the existing DMux8Way module.
- Read selection is an 8-way WIDTH-bit mux: either the existing Mux8Way16 when WIDTH=16, or a case statement inside ram8.

Test Plan:
- Reset: drive rst_n=0 with address swept 0..7 -> out=16'h0000 for every address. Release rst_n, then sweep again with load=0 -> out=16'h0000 for every address.
- Write and read all words: for k=0..7, write in=16'h1111*k+1 with load=1 at address k. Then read back with load=0 -> each address k returns its own value, e.g. address 3 -> 16'h3334, address 7 -> 16'h7778.
- Isolation:
  - Write 16'hBEEF at address 5, then in=16'h0000 with load=0 at address 5 for 3 cycles -> address 5 still reads 16'hBEEF.
  - Addresses 4 and 6 are unchanged.
- Read-during-write: address 2 holds 16'h00AA; set in=16'h5555, load=1 -> out=16'h00AA before the edge and out=16'h5555 after the edge.
- Combinational read: change address 1->6 mid-cycle with no clk edge -> out switches to mem[6] in the same time step.
- Async reset mid-operation: write 16'hFFFF to all words, then pulse rst_n low between clk edges.
  - out=16'h0000 immediately on all addresses.
  - A load=1 edge during reset leaves the words at 0.

Source files
------------

// File: rtl/ram8_pkg.sv
// Shared constants and the load-routing helper for the Hack-style RAM8 register file.
package ram8_pkg;

  localparam int HACK_WORD_W = 16;
  localparam int RAM8_ADDR_W = 3;
  localparam int RAM8_DEPTH  = 8;

  // 8-way load demultiplexer: drives load onto exactly the line picked by addr.
  function automatic logic [RAM8_DEPTH-1:0] dmux8(input logic load,
                                                   input logic [RAM8_ADDR_W-1:0] addr);
    logic [RAM8_DEPTH-1:0] lines;
    lines       = '0;
    lines[addr] = load;
    return lines;
  endfunction

endpackage

// File: rtl/ram8_word_reg.sv
// One WIDTH-bit storage word: asynchronous clear, synchronous load.
module word_reg
  import ram8_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  // NOTE: the words are discrete flops rather than a RAM macro, so every one
  // can be cleared by reset; state is updated with non-blocking assignments
  // so all eight words sample in/load from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (load) begin
      out <= in;
    end
  end

endmodule

// File: rtl/ram8.sv
// Eight-word register file: demultiplexed load into eight word_reg instances,
// combinational 8-way read mux on the same address.
module ram8
  import ram8_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic [RAM8_ADDR_W-1:0] address,
  output logic [WIDTH-1:0]       out
);

  logic [RAM8_DEPTH-1:0] en;
  logic [WIDTH-1:0]      words [RAM8_DEPTH];

  assign en = dmux8(load, address);

  for (genvar k = 0; k < RAM8_DEPTH; k++) begin : g_word
    word_reg #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .load  (en[k]),
      .out   (words[k])
    );
  end

  // Read path is purely combinational: no bypass of in, so a write shows up
  // only after the edge that stores it.
  // NOTE: out gets a default before the case so no path can infer a latch.
  always_comb begin
    out = '0;
    case (address)
      3'd0: out = words[0];
      3'd1: out = words[1];
      3'd2: out = words[2];
      3'd3: out = words[3];
      3'd4: out = words[4];
      3'd5: out = words[5];
      3'd6: out = words[6];
      3'd7: out = words[7];
      default: out = '0;
    endcase
  end

endmodule

// File: tb/tb_ram8.sv
// Self-checking bench for ram8: directed steps plus random traffic against an array model.
`timescale 1ns/1ps
module tb_ram8;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  logic [15:0] model [8];
  int          n_checks;
  int          n_fail;

  ram8 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a write mid-cycle, let one rising edge take it, return #1 after the edge.
  task automatic write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    in      = d;
    load    = 1'b1;
    @(posedge clk);
    if (rst_n) model[a] = d;
    #1;
    load = 1'b0;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 8; k++) model[k] = 16'h0000;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_model();
    rst_n   = 1'b0;
    load    = 1'b0;
    in      = 16'h0000;
    address = 3'd0;

    // Reset held: every address reads zero.
    #2;
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #1;
      check($sformatf("reset_hold[%0d]", k), out, 16'h0000);
    end

    // Release away from any edge, then sweep with load=0 across edges.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      address = 3'(k);
      #1;
      check($sformatf("reset_released[%0d]", k), out, 16'h0000);
    end

    // Write each word with its own pattern, then read everything back.
    for (int k = 0; k < 8; k++) write(3'(k), 16'(16'h1111 * k + 1));
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #1;
      check($sformatf("readback[%0d]", k), out, model[k]);
    end
    address = 3'd3;
    #1;
    check("readback_addr3_const", out, 16'h3334);
    address = 3'd7;
    #1;
    check("readback_addr7_const", out, 16'h7778);

    // Isolation: load=0 must not disturb the stored word or its neighbours.
    write(3'd5, 16'hBEEF);
    @(negedge clk);
    address = 3'd5;
    in      = 16'h0000;
    load    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("isolation_addr5", out, 16'hBEEF);
    address = 3'd4;
    #1;
    check("isolation_addr4", out, model[4]);
    address = 3'd6;
    #1;
    check("isolation_addr6", out, model[6]);

    // Read-during-write: old value before the edge, new value after.
    write(3'd2, 16'h00AA);
    @(negedge clk);
    address = 3'd2;
    in      = 16'h5555;
    load    = 1'b1;
    #1;
    check("rdw_before_edge", out, 16'h00AA);
    @(posedge clk);
    model[2] = 16'h5555;
    #1;
    check("rdw_after_edge", out, 16'h5555);
    load = 1'b0;

    // Combinational read: address change mid-cycle, no edge in between.
    @(negedge clk);
    address = 3'd1;
    #1;
    check("comb_read_addr1", out, model[1]);
    address = 3'd6;
    #1;
    check("comb_read_addr6", out, model[6]);

    // Random traffic against the array model.
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  a;
      logic [15:0] d;
      logic        l;
      a = 3'($urandom_range(0, 7));
      d = 16'($urandom);
      l = 1'($urandom_range(0, 1));
      @(negedge clk);
      address = a;
      in      = d;
      load    = l;
      #1;
      check($sformatf("rand_pre[%0d]", i), out, model[a]);
      @(posedge clk);
      if (l) model[a] = d;
      #1;
      check($sformatf("rand_post[%0d]", i), out, model[a]);
    end
    load = 1'b0;

    // Async reset mid-operation, including the word written on the preceding edge.
    for (int k = 0; k < 8; k++) write(3'(k), 16'hFFFF);
    address = 3'd7;
    #1;
    check("pre_reset_full", out, 16'hFFFF);
    rst_n = 1'b0;
    clear_model();
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #0.5;
      check($sformatf("async_clear[%0d]", k), out, 16'h0000);
    end

    // A load edge while reset is held must not write.
    write(3'd3, 16'h1234);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #1;
      check($sformatf("load_in_reset[%0d]", k), out, 16'h0000);
    end

    // First write after release lands on the first rising edge.
    rst_n = 1'b1;
    write(3'd3, 16'hA5C3);
    check("first_write_after_release", out, 16'hA5C3);
    address = 3'd2;
    #1;
    check("neighbour_after_release", out, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
